// File: rtl/btn_pkg.sv
// Shared definitions for the button input stage: FSM state encoding and
// default timing constants for the 100 MHz board clock.
package btn_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRESS1 = 3'd1;
  localparam logic [2:0] ST_LONG   = 3'd2;
  localparam logic [2:0] ST_WAIT2  = 3'd3;
  localparam logic [2:0] ST_PRESS2 = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    PRESS1 = ST_PRESS1,
    LONG   = ST_LONG,
    WAIT2  = ST_WAIT2,
    PRESS2 = ST_PRESS2
  } state_e;

  localparam int unsigned DEF_LONG_CYCLES   = 50_000_000;  // 500 ms
  localparam int unsigned DEF_GAP_CYCLES    = 25_000_000;  // 250 ms
  localparam int unsigned DEF_REPEAT_CYCLES = 10_000_000;  // 100 ms

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// One-register edge detector: rise/fall are combinational decodes of the
// current input against its previous-cycle sample.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic btn_q;

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) btn_q <= 1'b0;
    else     btn_q <= d;
  end

  assign rise = d & ~btn_q;
  assign fall = ~d & btn_q;

endmodule

// File: rtl/button_event_classifier.sv
// Turns the debounced button level into press/release/short/long/double pulses.
// Optional auto-repeat while held after a long press: define BTN_AUTO_REPEAT_EN.
module button_event_classifier
  import btn_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_W = $clog2(max3(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES) + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic repeat_pulse
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  logic             rise, fall;
  state_e           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             short_n, long_n, double_n;

  edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (btn_in),
    .rise (rise),
    .fall (fall)
  );

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic repeat_n;
`endif

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + CNT_W'(1);
    short_n  = 1'b0;
    long_n   = 1'b0;
    double_n = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
    repeat_n = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (rise) state_n = PRESS1;
      end
      // Release wins over a coinciding long threshold.
      PRESS1: begin
        if (fall) state_n = WAIT2;
        else if (cnt == LONG_LAST) begin
          long_n  = 1'b1;
          state_n = LONG;
        end
      end
      LONG: begin
`ifdef BTN_AUTO_REPEAT_EN
        if (fall) state_n = IDLE;
        else if (cnt == REPEAT_LAST) begin
          repeat_n = 1'b1;
          cnt_n    = '0;
        end
`else
        cnt_n = '0;
        if (fall) state_n = IDLE;
`endif
      end
      // A second press wins over a coinciding gap expiry.
      WAIT2: begin
        if (rise) state_n = PRESS2;
        else if (cnt == GAP_LAST) begin
          short_n = 1'b1;
          state_n = IDLE;
        end
      end
      PRESS2: begin
        cnt_n = '0;
        if (fall) begin
          double_n = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n != state) cnt_n = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      double_press  <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      press_pulse   <= rise;
      release_pulse <= fall;
      short_press   <= short_n;
      long_press    <= long_n;
      double_press  <= double_n;
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) repeat_pulse <= 1'b0;
    else     repeat_pulse <= repeat_n;
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule
